strassen_tile_feeder: RTL and testbench

STRASSEN_TILE_FEEDER -- requirements
Module: strassen_tile_feeder

---
 rtl/strassen_tile_feeder_if.sv | 26 ++
 rtl/strassen_tile_feeder.sv | 98 +++++++++
 tb/tb_strassen_tile_feeder.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/strassen_tile_feeder_if.sv
// strassen_tile_feeder_if: element stream in, 2x2 block beats out.
interface strassen_tile_feeder_if #(
    parameter int DATAWIDTH = 32,
    parameter int BUSWIDTH  = 4*DATAWIDTH
);
    logic signed [DATAWIDTH-1:0] in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic                        hold;
    logic [BUSWIDTH-1:0]         blk_a;
    logic [BUSWIDTH-1:0]         blk_b;
    logic                        load;
    logic                        sel;
    logic [1:0]                  tag_ik;
    logic                        tag_j;
    logic                        last;
    logic                        done;
    modport master (
        input  in_data, in_valid, hold,
        output in_ready, blk_a, blk_b, load, sel, tag_ik, tag_j, last, done
    );
    modport slave (
        output in_data, in_valid, hold,
        input  in_ready, blk_a, blk_b, load, sel, tag_ik, tag_j, last, done
    );
endinterface

// File: rtl/strassen_tile_feeder.sv
// strassen_tile_feeder: buffers a 4x4 A and 4x4 B, then issues the 8 block-product beats.
module strassen_tile_feeder #(
    parameter int DATAWIDTH = 32,
    parameter int BUSWIDTH  = 4*DATAWIDTH
) (
    input logic clk,
    input logic rst,
    strassen_tile_feeder_if.master bus
);
    localparam logic [0:0] FILL  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;
    logic [0:0]           state_q, state_d;
    logic [4:0]           word_q, word_d;
    logic [2:0]           beat_q, beat_d;
    logic                 load_q, load_d, last_q, last_d, done_q, done_d;
    logic [1:0]           tag_ik_q, tag_ik_d;
    logic                 tag_j_q, tag_j_d;
    logic [BUSWIDTH-1:0]  blk_a_q, blk_a_d, blk_b_q, blk_b_d;
    logic [DATAWIDTH-1:0] mem_q [32];
    logic                 accept, present;
    // base is the buffer index of the block's top-left element; rows are 4 words apart
    function automatic logic [4*DATAWIDTH-1:0] pack_blk(input logic [4:0] base);
        return {mem_q[base+5'd5], mem_q[base+5'd4], mem_q[base+5'd1], mem_q[base]};
    endfunction
    assign accept = bus.in_valid && (state_q == FILL);
    always_comb begin
        state_d  = state_q;
        word_d   = accept ? word_q + 5'd1 : word_q;
        beat_d   = beat_q;
        load_d   = 1'b0;
        last_d   = last_q;
        done_d   = 1'b0;
        tag_ik_d = tag_ik_q;
        tag_j_d  = tag_j_q;
        blk_a_d  = blk_a_q;
        blk_b_d  = blk_b_q;
        present  = 1'b0;
        if (state_q == FILL) begin
            if (accept && word_q == 5'd31) begin
                state_d = ISSUE;
                present = 1'b1;
            end
        end else if (last_q) begin
            state_d = FILL;
            last_d  = 1'b0;
            done_d  = 1'b1;
        end else begin
            present = !bus.hold;
        end
        // beat index is {i,k,j}: A block (i,j), B block (j,k)
        if (present) begin
            load_d   = 1'b1;
            last_d   = beat_q == 3'd7;
            beat_d   = beat_q + 3'd1;
            tag_ik_d = beat_q[2:1];
            tag_j_d  = beat_q[0];
            blk_a_d  = pack_blk({1'b0, beat_q[2], 1'b0, beat_q[0], 1'b0});
            blk_b_d  = pack_blk({1'b1, beat_q[0], 1'b0, beat_q[1], 1'b0});
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FILL;
            word_q   <= '0;
            beat_q   <= '0;
            load_q   <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
            tag_ik_q <= '0;
            tag_j_q  <= 1'b0;
            blk_a_q  <= '0;
            blk_b_q  <= '0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            beat_q   <= beat_d;
            load_q   <= load_d;
            last_q   <= last_d;
            done_q   <= done_d;
            tag_ik_q <= tag_ik_d;
            tag_j_q  <= tag_j_d;
            blk_a_q  <= blk_a_d;
            blk_b_q  <= blk_b_d;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && accept) mem_q[word_q] <= bus.in_data;
    end
    assign bus.in_ready = state_q == FILL;
    assign bus.load     = load_q;
    assign bus.last     = last_q;
    assign bus.done     = done_q;
    assign bus.tag_ik   = tag_ik_q;
    assign bus.tag_j    = tag_j_q;
    assign bus.blk_a    = blk_a_q;
    assign bus.blk_b    = blk_b_q;
    assign bus.sel      = 1'b0;
endmodule

// File: tb/tb_strassen_tile_feeder.sv
// tb_strassen_tile_feeder: random jobs checked against a matrix-level block model.
module tb_strassen_tile_feeder;
    localparam int D = 32;
    localparam int W = 4*D;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    strassen_tile_feeder_if #(.DATAWIDTH(D), .BUSWIDTH(W)) bus();
    strassen_tile_feeder #(.DATAWIDTH(D), .BUSWIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    logic [D-1:0] a_m [16];
    logic [D-1:0] b_m [16];
    int checks = 0;
    int errors = 0;
    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    // beat n multiplies A block (i,j) by B block (j,k), n = 4i + 2k + j
    function automatic logic [W-1:0] exp_blk(input bit is_b, input int n);
        int i = n / 4;
        int k = (n / 2) % 2;
        int j = n % 2;
        logic [W-1:0] v = '0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                v[(2*r+c)*D +: D] = is_b ? b_m[(2*j+r)*4 + 2*k + c] : a_m[(2*i+r)*4 + 2*j + c];
        return v;
    endfunction
    task automatic pattern();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                a_m[4*r+c] = D'(4*r + c);
                b_m[4*r+c] = D'(100 + 4*r + c);
            end
    endtask
    task automatic rand_mats();
        for (int n = 0; n < 16; n++) begin
            a_m[n] = $urandom;
            b_m[n] = $urandom;
        end
    endtask
    task automatic do_rst();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.hold = 1'b1;
        bus.in_data = $urandom;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", W'(bus.in_ready), W'(1));
        chk("rst_load", W'(bus.load), W'(0));
        chk("rst_last", W'(bus.last), W'(0));
        chk("rst_done", W'(bus.done), W'(0));
        chk("rst_tag_ik", W'(bus.tag_ik), W'(0));
        chk("rst_tag_j", W'(bus.tag_j), W'(0));
        chk("rst_blk_a", bus.blk_a, W'(0));
        chk("rst_blk_b", bus.blk_b, W'(0));
        chk("rst_sel", W'(bus.sel), W'(0));
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.hold = 1'b0;
    endtask
    task automatic feed(input int pct, input int nw);
        int n = 0;
        int cyc = 0;
        while (n < nw && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            chk("fill_in_ready", W'(bus.in_ready), W'(1));
            bus.in_valid = int'($urandom_range(99)) < pct;
            bus.in_data = n < 16 ? a_m[n % 16] : b_m[n % 16];
            bus.hold = 1'($urandom);
            @(posedge clk);
            if (bus.in_valid) n++;
        end
        chk("feed_count", W'(n), W'(nw));
    endtask
    task automatic collect(input int hold_beat, input int hold_len);
        int cnt = 0;
        int stalls = 0;
        int cyc = 0;
        int hrem = hold_len;
        bit fin = 1'b0;
        while (!fin && cyc < 300) begin
            @(negedge clk);
            cyc++;
            chk("sel", W'(bus.sel), W'(0));
            if (bus.load) begin
                if (cnt < 8) begin
                    chk("beat_blk_a", bus.blk_a, exp_blk(1'b0, cnt));
                    chk("beat_blk_b", bus.blk_b, exp_blk(1'b1, cnt));
                    chk("beat_tag_ik", W'(bus.tag_ik), W'(cnt / 2));
                    chk("beat_tag_j", W'(bus.tag_j), W'(cnt % 2));
                    chk("beat_last", W'(bus.last), W'(cnt == 7));
                    chk("beat_in_ready", W'(bus.in_ready), W'(0));
                    chk("beat_done", W'(bus.done), W'(0));
                end
                cnt++;
            end else if (!bus.in_ready) begin
                stalls++;
                if (cnt > 0) begin
                    chk("stall_blk_a", bus.blk_a, exp_blk(1'b0, cnt - 1));
                    chk("stall_blk_b", bus.blk_b, exp_blk(1'b1, cnt - 1));
                    chk("stall_tag_ik", W'(bus.tag_ik), W'((cnt - 1) / 2));
                    chk("stall_tag_j", W'(bus.tag_j), W'((cnt - 1) % 2));
                end
            end else begin
                chk("done_pulse", W'(bus.done), W'(1));
                chk("done_last", W'(bus.last), W'(0));
                fin = 1'b1;
            end
            bus.hold = cnt == hold_beat && hrem > 0;
            if (bus.hold) hrem--;
            bus.in_valid = !bus.in_ready;
            bus.in_data = $urandom;
        end
        chk("job_finished", W'(fin), W'(1));
        chk("beat_count", W'(cnt), W'(8));
        chk("stall_count", W'(stalls), W'(hold_len));
        bus.hold = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", W'(bus.done), W'(0));
    endtask
    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.hold = 1'b0;
        do_rst();
        pattern();
        feed(100, 32);
        collect(0, 0);
        feed(50, 32);
        collect(0, 0);
        feed(100, 32);
        collect(4, 3);
        rand_mats();
        feed(100, 10);
        do_rst();
        pattern();
        feed(100, 32);
        collect(0, 0);
        a_m[0] = '1;
        feed(70, 32);
        collect(0, 0);
        rand_mats();
        feed(100, 32);
        collect(0, 0);
        rand_mats();
        feed(100, 32);
        repeat (3) @(negedge clk);
        do_rst();
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            chk("abort_done", W'(bus.done), W'(0));
            chk("abort_load", W'(bus.load), W'(0));
        end
        pattern();
        feed(100, 32);
        collect(0, 0);
        for (int t = 0; t < 5; t++) begin
            rand_mats();
            feed(int'($urandom_range(100, 30)), 32);
            collect(int'($urandom_range(7, 1)), int'($urandom_range(4, 0)));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
